// File: rtl/floppy_pkg.sv
// Shared constants for the floppy register bank: register map, ID version and note tables.
// The semitone table holds half-period clock counts at 50 MHz for MIDI octave -1.
package floppy_pkg;

    localparam logic [5:0] NOTE_BASE = 6'h00;
    localparam logic [5:0] DUR_BASE  = 6'h10;
    localparam logic [5:0] CTRL      = 6'h20;
    localparam logic [5:0] STAT_LO   = 6'h21;
    localparam logic [5:0] STAT_HI   = 6'h22;
    localparam logic [5:0] ID        = 6'h3F;

    localparam logic [3:0] ID_VERSION   = 4'h2;
    localparam int         SP_W_DEFAULT = 22;

    typedef struct packed {
        logic freeze;
        logic mute;
    } ctrl_t;

    function automatic logic [21:0] semitone_base(input logic [3:0] semi);
        logic [21:0] base;
        case (semi)
            4'd0:    base = 22'd3057805;
            4'd1:    base = 22'd2886170;
            4'd2:    base = 22'd2724196;
            4'd3:    base = 22'd2571301;
            4'd4:    base = 22'd2426984;
            4'd5:    base = 22'd2290762;
            4'd6:    base = 22'd2162204;
            4'd7:    base = 22'd2040841;
            4'd8:    base = 22'd1926300;
            4'd9:    base = 22'd1818182;
            4'd10:   base = 22'd1716137;
            4'd11:   base = 22'd1619816;
            default: base = 22'd0;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/floppy_channel.sv
// One tone channel: NOTE/DUR registers, remaining-ticks timer with auto-off, and setpoint lookup.
// A NOTE write on the same edge as an expiry wins and suppresses the expire pulse.
module floppy_channel
    import floppy_pkg::*;
#(
    parameter int SP_W = SP_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tick_i,
    input  logic            note_we_i,
    input  logic            dur_we_i,
    input  logic [7:0]      wdata_i,
    output logic [7:0]      note_o,
    output logic [7:0]      dur_o,
    output logic            expire_o,
    output logic [SP_W-1:0] sp_o
);

    logic [7:0] note_q, note_d;
    logic [7:0] dur_q, dur_d;
    logic [7:0] rem_q, rem_d;
    logic       expire_q, expire_d;

    always_comb begin
        note_d   = note_q;
        dur_d    = dur_q;
        rem_d    = rem_q;
        expire_d = 1'b0;
        // DUR of zero means sustain: the timer never runs.
        if (tick_i && note_q[7] && (dur_q != 8'd0) && (rem_q != 8'd0)) begin
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
                note_d[7] = 1'b0;
                expire_d  = 1'b1;
            end
        end
        if (dur_we_i) begin
            dur_d = wdata_i;
        end
        if (note_we_i) begin
            note_d   = wdata_i;
            rem_d    = wdata_i[7] ? dur_q : 8'd0;
            expire_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            note_q   <= 8'd0;
            dur_q    <= 8'd0;
            rem_q    <= 8'd0;
            expire_q <= 1'b0;
        end else begin
            note_q   <= note_d;
            dur_q    <= dur_d;
            rem_q    <= rem_d;
            expire_q <= expire_d;
        end
    end

    assign note_o   = note_q;
    assign dur_o    = dur_q;
    assign expire_o = expire_q;

    floppy_lookup #(.SP_W(SP_W)) u_lookup (
        .note_i (note_q[6:0]),
        .sp_o   (sp_o)
    );

endmodule

// File: rtl/floppy_lookup.sv
// Maps a 7-bit MIDI note to a step-generator setpoint (half-period in clocks).
// Each octave up halves the semitone's base count.
module floppy_lookup
    import floppy_pkg::*;
#(
    parameter int SP_W = SP_W_DEFAULT
) (
    input  logic [6:0]      note_i,
    output logic [SP_W-1:0] sp_o
);

    logic [3:0]  semi;
    logic [3:0]  octave;
    logic [21:0] base_sp;

    always_comb begin
        semi    = 4'(note_i % 7'd12);
        octave  = 4'(note_i / 7'd12);
        base_sp = semitone_base(semi) >> octave;
    end

    assign sp_o = SP_W'(base_sp);

endmodule

// File: rtl/floppy_reg_bank.sv
// Byte-wide register bank for NUM_CH floppy tone channels: bus decode, read mux,
// global CTRL (mute/freeze) and the duration-tick prescaler.
module floppy_reg_bank
    import floppy_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int TICK_DIV = 500000,
    parameter int SP_W     = SP_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             reg_addr,
    input  logic                   write,
    input  logic                   new_req,
    input  logic [7:0]             write_value,
    output logic [7:0]             read_value,
    output logic                   read_valid,
    output logic [NUM_CH-1:0]      led,
    output logic [NUM_CH*SP_W-1:0] ch_sp,
    output logic [NUM_CH-1:0]      ch_en,
    output logic [NUM_CH-1:0]      expire
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]     NUM_CH_5  = 5'(NUM_CH);

    // Bus handshake: new_req is a one-cycle strobe accepted every cycle; a read returns
    // read_value with a one-cycle read_valid pulse exactly one cycle after its strobe.
    logic       wr_req, rd_req;
    logic [3:0] ch_idx;
    logic       ch_hit, note_sel, dur_sel;

    ctrl_t          ctrl_q, ctrl_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           tick;
    logic [7:0]     read_value_q, read_value_d;
    logic           read_valid_q;
    logic [7:0]     rdata;

    logic [7:0]        note_w [NUM_CH];
    logic [7:0]        dur_w  [NUM_CH];
    logic [NUM_CH-1:0] note_en;
    logic [15:0]       stat_all;

    assign wr_req   = new_req & write;
    assign rd_req   = new_req & ~write;
    assign ch_idx   = reg_addr[3:0];
    assign ch_hit   = {1'b0, ch_idx} < NUM_CH_5;
    assign note_sel = (reg_addr[5:4] == NOTE_BASE[5:4]) & ch_hit;
    assign dur_sel  = (reg_addr[5:4] == DUR_BASE[5:4]) & ch_hit;

    assign tick = ~ctrl_q.freeze & (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        if (!ctrl_q.freeze) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_req && (reg_addr == CTRL)) begin
            ctrl_d.freeze = write_value[1];
            ctrl_d.mute   = write_value[0];
        end
    end

    always_comb begin
        stat_all = 16'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            stat_all[i] = note_en[i];
        end
    end

    always_comb begin
        rdata = 8'd0;
        case (reg_addr)
            CTRL:    rdata = {6'd0, ctrl_q};
            STAT_LO: rdata = stat_all[7:0];
            STAT_HI: rdata = stat_all[15:8];
            ID:      rdata = {ID_VERSION, 4'(NUM_CH - 1)};
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (note_sel && (ch_idx == 4'(i))) rdata = note_w[i];
                    if (dur_sel && (ch_idx == 4'(i)))  rdata = dur_w[i];
                end
            end
        endcase
    end

    assign read_value_d = rd_req ? rdata : read_value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q       <= '0;
            presc_q      <= '0;
            read_value_q <= 8'd0;
            read_valid_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            presc_q      <= presc_d;
            read_value_q <= read_value_d;
            read_valid_q <= rd_req;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_expire;
        logic [SP_W-1:0] ch_setpoint;

        floppy_channel #(.SP_W(SP_W)) u_channel (
            .clk_i     (clk),
            .rst_i     (rst),
            .tick_i    (tick),
            .note_we_i (wr_req & note_sel & (ch_idx == 4'(i))),
            .dur_we_i  (wr_req & dur_sel & (ch_idx == 4'(i))),
            .wdata_i   (write_value),
            .note_o    (note_w[i]),
            .dur_o     (dur_w[i]),
            .expire_o  (ch_expire),
            .sp_o      (ch_setpoint)
        );

        assign note_en[i]              = note_w[i][7];
        assign expire[i]               = ch_expire;
        assign ch_sp[i*SP_W +: SP_W]   = ch_setpoint;
    end

    assign ch_en      = note_en & {NUM_CH{~ctrl_q.mute}};
    assign led        = ch_en;
    assign read_value = read_value_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_floppy_reg_bank.sv
// Randomised and directed bench for floppy_reg_bank against a register-level reference model.
// The model tracks register contents, remaining ticks and the prescaler phase as plain integers.
module tb_floppy_reg_bank;

    localparam int NUM_CH   = 8;
    localparam int TICK_DIV = 4;
    localparam int SP_W     = 22;

    logic                   clk;
    logic                   rst;
    logic [5:0]             reg_addr;
    logic                   write;
    logic                   new_req;
    logic [7:0]             write_value;
    logic [7:0]             read_value;
    logic                   read_valid;
    logic [NUM_CH-1:0]      led;
    logic [NUM_CH*SP_W-1:0] ch_sp;
    logic [NUM_CH-1:0]      ch_en;
    logic [NUM_CH-1:0]      expire;

    floppy_reg_bank #(.NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .SP_W(SP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_addr    (reg_addr),
        .write       (write),
        .new_req     (new_req),
        .write_value (write_value),
        .read_value  (read_value),
        .read_valid  (read_valid),
        .led         (led),
        .ch_sp       (ch_sp),
        .ch_en       (ch_en),
        .expire      (expire)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int         m_note [NUM_CH];
    int         m_dur  [NUM_CH];
    int         m_rem  [NUM_CH];
    int         m_ctrl;
    int         m_presc;
    logic [7:0] m_exp;
    bit         m_rv;
    int         m_rdval;
    logic [7:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    int base_tab [12] = '{3057805, 2886170, 2724196, 2571301, 2426984, 2290762,
                          2162204, 2040841, 1926300, 1818182, 1716137, 1619816};

    function automatic int lookup(input int n);
        return base_tab[n % 12] >> (n / 12);
    endfunction

    function automatic int model_read(input int a);
        int s;
        if (a < NUM_CH) return m_note[a];
        if (a >= 16 && a < 16 + NUM_CH) return m_dur[a - 16];
        if (a == 32) return m_ctrl;
        if (a == 33) begin
            s = 0;
            for (int i = 0; i < NUM_CH; i++) if (m_note[i] >= 128) s += (1 << i);
            return s;
        end
        if (a == 63) return 32 + NUM_CH - 1;
        return 0;
    endfunction

    function automatic bit tick_next();
        return ((m_ctrl & 2) == 0) && (m_presc == TICK_DIV - 1);
    endfunction

    task automatic model_step(input bit r, input bit req, input bit wr, input int a, input int d);
        bit tk;
        int v;
        if (r) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_note[i] = 0; m_dur[i] = 0; m_rem[i] = 0;
            end
            m_ctrl = 0; m_presc = 0; m_exp = '0; m_rv = 0; m_rdval = 0;
            exp_q.delete();
            return;
        end
        m_rv = 0;
        if (req && !wr) begin
            v = model_read(a);
            exp_q.push_back(8'(v));
            m_rv = 1;
            m_rdval = v;
        end
        tk = tick_next();
        if ((m_ctrl & 2) == 0) m_presc = (m_presc + 1) % TICK_DIV;
        m_exp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tk && m_note[i] >= 128 && m_dur[i] != 0 && m_rem[i] != 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_note[i] -= 128;
                    m_exp[i] = 1'b1;
                end
            end
        end
        if (req && wr) begin
            if (a < NUM_CH) begin
                m_note[a] = d;
                m_rem[a]  = (d >= 128) ? m_dur[a] : 0;
                m_exp[a]  = 1'b0;
            end else if (a >= 16 && a < 16 + NUM_CH) begin
                m_dur[a - 16] = d;
            end else if (a == 32) begin
                m_ctrl = d & 3;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] en;
        for (int i = 0; i < NUM_CH; i++) en[i] = (m_note[i] >= 128) && ((m_ctrl & 1) == 0);
        check_eq("ch_en", 32'(ch_en), 32'(en));
        check_eq("led", 32'(led), 32'(en));
        check_eq("expire", 32'(expire), 32'(m_exp));
        check_eq("read_valid", 32'(read_valid), 32'(m_rv));
        if (read_valid) begin
            if (exp_q.size() == 0) check_eq("rd_unexpected", 32'(read_valid), 32'd0);
            else check_eq("rd_data", 32'(read_value), 32'(exp_q.pop_front()));
        end
        check_eq("rd_hold", 32'(read_value), 32'(m_rdval));
        for (int i = 0; i < NUM_CH; i++) begin
            check_eq($sformatf("ch_sp%0d", i), 32'(ch_sp[i*SP_W +: SP_W]),
                     32'(lookup(m_note[i] & 127)));
        end
    endtask

    // driver: one bus cycle, model update on the edge, check 1 time unit later
    task automatic step(input bit r, input bit req, input bit wr, input int a, input int d);
        rst = r; new_req = req; write = wr;
        reg_addr = 6'(a); write_value = 8'(d);
        @(posedge clk);
        model_step(r, req, wr, a, d);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic bus_write(input int a, input int d);
        step(0, 1, 1, a, d);
    endtask

    task automatic bus_read(input int a);
        step(0, 1, 0, a, 0);
    endtask

    initial begin
        int k;
        int cnt;
        bit found;
        int sel, a, d;

        rst = 1'b1; new_req = 1'b0; write = 1'b0; reg_addr = '0; write_value = '0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_eq("rst_sp0", 32'(ch_sp[0 +: SP_W]), 32'd3057805);

        // back-to-back reads of the whole map after reset
        for (int i = 0; i < 64; i++) bus_read(i);
        check_eq("id_read", 32'(read_value), 32'h27);
        idle();

        bus_write(3, 8'hC5);
        check_eq("note3_en", 32'(ch_en[3]), 32'd1);
        check_eq("note3_sp", 32'(ch_sp[3*SP_W +: SP_W]), 32'(lookup(8'h45)));
        bus_read(3);
        check_eq("note3_rd", 32'(read_value), 32'hC5);
        check_eq("note3_rv", 32'(read_valid), 32'd1);

        // auto-off after exactly 3 ticks
        bus_write(16 + 2, 3);
        bus_write(2, 8'h80 | 60);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            idle();
            if (expire[2]) k = i;
        end
        check_eq("exp2_window", 32'((k >= 9) && (k <= 12)), 32'd1);
        bus_read(2);
        check_eq("note2_after_exp", 32'(read_value), 32'h3C);

        // retrigger on the expiry edge
        bus_write(2, 8'h80 | 60);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tick_next() && m_rem[2] == 1 && m_note[2] >= 128) found = 1;
            else idle();
        end
        if (found) begin
            bus_write(2, 8'h80 | 60);
            check_eq("retrig_no_expire", 32'(expire[2]), 32'd0);
            check_eq("retrig_en", 32'(ch_en[2]), 32'd1);
            k = 0;
            for (int i = 1; i <= 20 && k == 0; i++) begin
                idle();
                if (expire[2]) k = i;
            end
            check_eq("retrig_reload", 32'(k), 32'd12);
        end

        // mute and freeze
        bus_write(2, 8'h80 | 60);
        bus_write(32, 8'h01);
        check_eq("mute_en", 32'(ch_en), 32'd0);
        bus_read(33);
        check_eq("mute_stat", 32'(read_value), 32'h0C);
        bus_write(16 + 5, 2);
        bus_write(5, 8'h80 | 50);
        bus_write(32, 8'h02);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            idle();
            if (expire[5]) cnt++;
        end
        check_eq("freeze_hold", 32'(cnt), 32'd0);
        bus_write(32, 8'h00);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            idle();
            if (expire[5]) k = i;
        end
        check_eq("unfreeze_expire", 32'(k != 0), 32'd1);

        // unmapped addresses
        bus_write(8, 8'hFF);
        bus_write(48, 8'hFF);
        bus_read(8);
        check_eq("unmapped_08", 32'(read_value), 32'd0);
        bus_read(48);
        check_eq("unmapped_30", 32'(read_value), 32'd0);

        // reset overrides an in-flight read
        bus_read(63);
        step(1, 1, 0, 63, 0);
        check_eq("rst_kills_read", 32'(read_valid), 32'd0);
        step(0, 0, 0, 0, 0);

        // randomised traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1, 0, 0, 0, 0);
            end else if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 4) begin
                    a = $urandom_range(0, 9);
                    d = $urandom_range(0, 255);
                end else if (sel < 7) begin
                    a = 16 + $urandom_range(0, 9);
                    d = $urandom_range(0, 4);
                end else if (sel < 8) begin
                    a = 32;
                    d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 0;
                end else if (sel < 9) begin
                    case ($urandom_range(0, 2))
                        0: a = 33;
                        1: a = 34;
                        default: a = 63;
                    endcase
                    d = $urandom_range(0, 255);
                end else begin
                    a = $urandom_range(0, 63);
                    d = $urandom_range(0, 255);
                end
                step(0, 1, $urandom_range(0, 1) == 1, a, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
